// File: rtl/mem_resp_pkg.sv
// rtl/mem_resp_pkg.sv - shared state enum, parity helper and defaults for mem_line_responder
package mem_resp_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WAIT = 3'd1,
        XFER = 3'd2,
        DONE = 3'd3,
        HOLD = 3'd4
    } state_t;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_WORDS   = 4;
    localparam int DEF_DEPTH   = 256;
    localparam int DEF_LATENCY = 8;

    // Words wider than this are not supported by parity_f.
    localparam int PAR_MAX_W = 256;

    // Even parity: the returned bit makes the total count of ones even.
    function automatic logic parity_f(input logic [PAR_MAX_W-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/mem_resp_line_store.sv
// rtl/mem_resp_line_store.sv - DEPTH x WORDS word array, sync write, comb read by {line, beat}; parity bit under MEM_RESP_PARITY_EN
module mem_resp_line_store
    import mem_resp_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int WORDS  = DEF_WORDS,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int LINE_W = $clog2(DEF_DEPTH),
    parameter int BEAT_W = $clog2(DEF_WORDS)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [LINE_W-1:0] line,
    input  logic [BEAT_W-1:0] beat,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rd_perr
);

    localparam int WSH = $clog2(WORDS);
    localparam int IW  = (DEPTH * WORDS > 1) ? $clog2(DEPTH * WORDS) : 1;

`ifdef MEM_RESP_PARITY_EN
    localparam int SW = DATA_W + 1;
`else
    localparam int SW = DATA_W;
`endif

    // Not reset: contents are undefined until a write-back lands.
    logic [SW-1:0] mem [DEPTH*WORDS];
    logic [IW-1:0] idx;

    assign idx = (IW'(line) << WSH) | IW'(beat);

    always_ff @(posedge clk) begin
        if (wr_en) begin
`ifdef MEM_RESP_PARITY_EN
            mem[idx] <= {parity_f(PAR_MAX_W'(wdata)), wdata};
`else
            mem[idx] <= wdata;
`endif
        end
    end

`ifdef MEM_RESP_PARITY_EN
    always_comb begin
        rdata   = mem[idx][DATA_W-1:0];
        rd_perr = parity_f(PAR_MAX_W'(mem[idx][DATA_W-1:0])) != mem[idx][DATA_W];
    end
`else
    always_comb begin
        rdata   = mem[idx];
        rd_perr = 1'b0;
    end
`endif

endmodule

// File: rtl/mem_line_responder.sv
// rtl/mem_line_responder.sv - latency-programmable line refill/write-back responder; optional parity via MEM_RESP_PARITY_EN
module mem_line_responder
    import mem_resp_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int WORDS   = DEF_WORDS,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     mem_req,
    input  logic                     mem_we,
    input  logic [$clog2(DEPTH)-1:0] mem_addr,
    input  logic [DATA_W-1:0]        mem_wdata,
    output logic                     mem_wack,
    output logic                     mem_rvalid,
    output logic [DATA_W-1:0]        mem_rdata,
    output logic                     mem_ready,
    output logic                     mem_perr
);

    localparam int LINE_W = $clog2(DEPTH);
    localparam int LAT_W  = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
    localparam int BEAT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS - 1);

    state_t              state, state_nx;
    logic [LAT_W-1:0]    lat_cnt;
    logic [BEAT_W-1:0]   beat_cnt;
    logic                we_q;
    logic [LINE_W-1:0]   addr_q;
    logic                store_wr;
    logic [DATA_W-1:0]   store_rdata;
    logic                store_perr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Request attributes are captured once at accept; later input changes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_cnt  <= '0;
            beat_cnt <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_req) begin
                        we_q     <= mem_we;
                        addr_q   <= mem_addr;
                        beat_cnt <= '0;
                        lat_cnt  <= LAT_W'(LATENCY);
                    end
                end
                WAIT: lat_cnt <= lat_cnt - LAT_W'(1);
                XFER: beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + BEAT_W'(1);
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (mem_req) begin
                    state_nx = (LATENCY == 0) ? XFER : WAIT;
                end
            end
            WAIT: begin
                if (lat_cnt == LAT_W'(1)) begin
                    state_nx = XFER;
                end
            end
            XFER: begin
                if (beat_cnt == LAST_BEAT) begin
                    state_nx = DONE;
                end
            end
            DONE: state_nx = HOLD;
            // A request still high after the completion pulse must not restart a transfer.
            HOLD: begin
                if (!mem_req) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        mem_wack   = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        mem_ready  = 1'b0;
        mem_perr   = 1'b0;
        store_wr   = 1'b0;
        if (state == XFER) begin
            if (we_q) begin
                mem_wack = 1'b1;
                store_wr = 1'b1;
            end else begin
                mem_rvalid = 1'b1;
                mem_rdata  = store_rdata;
                mem_perr   = store_perr;
            end
        end
        if (state == DONE) begin
            mem_ready = 1'b1;
        end
    end

    mem_resp_line_store #(
        .DATA_W (DATA_W),
        .WORDS  (WORDS),
        .DEPTH  (DEPTH),
        .LINE_W (LINE_W),
        .BEAT_W (BEAT_W)
    ) u_store (
        .clk     (clk),
        .wr_en   (store_wr),
        .line    (addr_q),
        .beat    (beat_cnt),
        .wdata   (mem_wdata),
        .rdata   (store_rdata),
        .rd_perr (store_perr)
    );

endmodule

// File: tb/tb_mem_line_responder.sv
// tb/tb_mem_line_responder.sv - timeline-model bench for mem_line_responder (LATENCY 8 and 0 instances); parity case under MEM_RESP_PARITY_EN
module tb_mem_line_responder;

    localparam int DW = 32;
    localparam int NW = 4;
    localparam int DP = 16;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]         req, we;
    logic [1:0][AW-1:0] addr;
    logic [1:0][DW-1:0] wdata;
    logic [1:0]         wack, rvalid, ready, perr;
    logic [1:0][DW-1:0] rdata;

    mem_line_responder #(.DATA_W(DW), .WORDS(NW), .DEPTH(DP), .LATENCY(8)) dut (
        .clk(clk), .rst_n(rst_n), .mem_req(req[0]), .mem_we(we[0]), .mem_addr(addr[0]),
        .mem_wdata(wdata[0]), .mem_wack(wack[0]), .mem_rvalid(rvalid[0]),
        .mem_rdata(rdata[0]), .mem_ready(ready[0]), .mem_perr(perr[0])
    );

    mem_line_responder #(.DATA_W(DW), .WORDS(NW), .DEPTH(DP), .LATENCY(0)) dut_l0 (
        .clk(clk), .rst_n(rst_n), .mem_req(req[1]), .mem_we(we[1]), .mem_addr(addr[1]),
        .mem_wdata(wdata[1]), .mem_wack(wack[1]), .mem_rvalid(rvalid[1]),
        .mem_rdata(rdata[1]), .mem_ready(ready[1]), .mem_perr(perr[1])
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: 0 = idle, 1 = transaction accepted at m_c0, 2 = waiting for request low.
    int          m_mode [2];
    int          m_c0   [2];
    logic        m_we   [2];
    int          m_addr [2];
    logic [DW-1:0] mem_m   [2][DP*NW];
    bit            known_m [2][DP*NW];
    bit            bad_m   [2][DP*NW];

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = 0;
            for (int j = 0; j < DP*NW; j++) begin
                known_m[i][j] = 1'b0;
                bad_m[i][j]   = 1'b0;
            end
        end
    end

    always @(negedge clk) begin : compare
        int t, k, lat, idx;
        logic e_beat, e_rdy;
        for (int i = 0; i < 2; i++) begin
            lat = (i == 0) ? 8 : 0;
            if (!rst_n) begin
                chk1("rst_wack", wack[i], 1'b0);
                chk1("rst_rvalid", rvalid[i], 1'b0);
                chk1("rst_ready", ready[i], 1'b0);
                chk1("rst_perr", perr[i], 1'b0);
                chk("rst_rdata", rdata[i], '0);
                m_mode[i] = 0;
                continue;
            end
            e_beat = 1'b0;
            e_rdy  = 1'b0;
            k      = 0;
            if (m_mode[i] == 1) begin
                t = cyc - m_c0[i];
                if (t >= lat + 1 && t <= lat + NW) begin
                    e_beat = 1'b1;
                    k = t - lat - 1;
                end
                if (t == lat + NW + 1) e_rdy = 1'b1;
            end
            idx = m_addr[i] * NW + k;
            chk1("wack", wack[i], e_beat && m_we[i]);
            chk1("rvalid", rvalid[i], e_beat && !m_we[i]);
            chk1("ready", ready[i], e_rdy);
            chk1("perr", perr[i], e_beat && !m_we[i] && bad_m[i][idx]);
            if (e_beat && !m_we[i] && known_m[i][idx]) chk("rdata", rdata[i], mem_m[i][idx]);
            case (m_mode[i])
                0: if (req[i]) begin
                    m_mode[i] = 1;
                    m_c0[i]   = cyc;
                    m_we[i]   = we[i];
                    m_addr[i] = int'(addr[i]);
                end
                1: begin
                    if (e_beat && m_we[i]) begin
                        mem_m[i][idx]   = wdata[i];
                        known_m[i][idx] = 1'b1;
                        bad_m[i][idx]   = 1'b0;
                    end
                    if (e_rdy) m_mode[i] = 2;
                end
                default: if (!req[i]) m_mode[i] = 0;
            endcase
        end
    end

    // One requester transaction; fb/rdy are cycle offsets from the accept cycle.
    task automatic run_txn(input int i, input logic w, input logic [AW-1:0] a,
                           input logic [DW-1:0] wd [NW], input int hold_x, input int rst_beat,
                           input int new_addr, input bit drop,
                           output int fb, output int rdy, output logic [DW-1:0] rd [NW]);
        int k;
        k = 0; fb = -1; rdy = -1;
        for (int j = 0; j < NW; j++) rd[j] = '0;
        @(posedge clk); #1;
        req[i] = 1'b1; we[i] = w; addr[i] = a; wdata[i] = wd[0];
        for (int off = 0; off < 40 && rdy < 0; off++) begin
            @(negedge clk);
            if (wack[i] || rvalid[i]) begin
                if (fb < 0) fb = off;
                if (k < NW) rd[k] = rdata[i];
                k++;
            end
            if (ready[i]) rdy = off;
            @(posedge clk); #1;
            if (off == 1) begin
                if (new_addr >= 0) addr[i] = AW'(new_addr);
                we[i] = ~w;
                if (drop) req[i] = 1'b0;
            end
            if (off == 2 && drop) req[i] = 1'b1;
            wdata[i] = (k < NW) ? wd[k] : DW'($urandom());
            if (rst_beat >= 0 && w && k == rst_beat) begin
                #2 rst_n = 1'b0;
                req[i] = 1'b0;
                @(posedge clk); #3;
                rst_n = 1'b1;
                return;
            end
        end
        if (rdy < 0) begin
            n_cmp++; n_bad++;
            $display("FAIL txn_timeout dut %0d line %0d: got no ready expected ready", i, a);
        end
        repeat (hold_x) begin @(posedge clk); #1; end
        req[i] = 1'b0;
    endtask

    logic [DW-1:0] wd [NW];
    logic [DW-1:0] rd [NW];
    int fb, rdy;

    initial begin : stim
        req = '0; we = '0; addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;

        wd = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        run_txn(0, 1'b1, 4'd5, wd, 0, -1, -1, 1'b0, fb, rdy, rd);
        chk_i("wb_first_wack", fb, 9);
        chk_i("wb_ready", rdy, 13);
        run_txn(0, 1'b0, 4'd5, wd, 0, -1, -1, 1'b0, fb, rdy, rd);
        chk_i("rf_first_beat", fb, 9);
        chk_i("rf_ready", rdy, 13);
        for (int j = 0; j < NW; j++) chk("rf_line5_word", rd[j], 32'hA0 + DW'(j));

        wd = '{32'h90, 32'h91, 32'h92, 32'h93};
        run_txn(0, 1'b1, 4'd9, wd, 0, -1, -1, 1'b0, fb, rdy, rd);
        wd = '{32'h70, 32'h71, 32'h72, 32'h73};
        run_txn(0, 1'b1, 4'd7, wd, 3, -1, -1, 1'b0, fb, rdy, rd);
        run_txn(0, 1'b0, 4'd7, wd, 0, -1, 9, 1'b1, fb, rdy, rd);
        chk_i("rearm_first_beat", fb, 9);
        for (int j = 0; j < NW; j++) chk("addr_change_word", rd[j], 32'h70 + DW'(j));

        wd = '{32'h11, 32'h12, 32'h13, 32'h14};
        run_txn(0, 1'b1, 4'd2, wd, 0, -1, -1, 1'b0, fb, rdy, rd);
        wd = '{32'h21, 32'h22, 32'h23, 32'h24};
        run_txn(0, 1'b1, 4'd2, wd, 0, 2, -1, 1'b0, fb, rdy, rd);
        run_txn(0, 1'b0, 4'd2, wd, 0, -1, -1, 1'b0, fb, rdy, rd);
        chk("rst_word0", rd[0], 32'h21);
        chk("rst_word1", rd[1], 32'h22);
        chk("rst_word2", rd[2], 32'h13);
        chk("rst_word3", rd[3], 32'h14);

        wd = '{32'hB0, 32'hB1, 32'hB2, 32'hB3};
        run_txn(1, 1'b1, 4'd0, wd, 0, -1, -1, 1'b0, fb, rdy, rd);
        run_txn(1, 1'b0, 4'd0, wd, 0, -1, -1, 1'b0, fb, rdy, rd);
        chk_i("lat0_first_beat", fb, 1);
        chk_i("lat0_ready", rdy, 5);
        for (int j = 0; j < NW; j++) chk("lat0_word", rd[j], 32'hB0 + DW'(j));

        for (int n = 0; n < 60; n++) begin
            for (int j = 0; j < NW; j++) wd[j] = DW'($urandom());
            run_txn(int'($urandom_range(0, 1)), 1'($urandom()), AW'($urandom()), wd,
                    int'($urandom_range(0, 3)), -1,
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, DP-1)) : -1,
                    1'($urandom()), fb, rdy, rd);
        end

`ifdef MEM_RESP_PARITY_EN
        for (int j = 0; j < NW; j++) wd[j] = DW'($urandom());
        run_txn(0, 1'b1, 4'd3, wd, 0, -1, -1, 1'b0, fb, rdy, rd);
        @(posedge clk); #1;
        dut.u_store.mem[3*NW+1][0] = ~dut.u_store.mem[3*NW+1][0];
        mem_m[0][3*NW+1][0] = ~mem_m[0][3*NW+1][0];
        bad_m[0][3*NW+1] = 1'b1;
        run_txn(0, 1'b0, 4'd3, wd, 0, -1, -1, 1'b0, fb, rdy, rd);
`endif

        repeat (4) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule

// File: doc/mem_line_responder.md
# mem_line_responder

Memory-side responder for the cache refill/write-back handshake. It accepts a line request from the cache's refill/write-back controller on `mem_req`, applies a programmable access latency, and then either streams a line out (refill) or absorbs a line in (write-back) one word per cycle. It signals completion with a single-cycle `mem_ready` pulse. It serves as the main-memory model in coherency benches and as the template for the real memory-controller front end.

## Interface
- `DATA_W`, default 32: word width.
- `WORDS`, default 4: words per cache line; power of two, at least 1.
- `DEPTH`, default 256: lines stored; power of two.
- `LATENCY`, default 8: wait cycles between accept and the first beat; 0 is legal.
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `mem_req`, in, 1: request, held high by the requester until it sees `mem_ready`.
- `mem_we`, in, 1: 1 = write-back, 0 = refill; sampled at accept.
- `mem_addr`, in, clog2(DEPTH): line index; sampled at accept.
- `mem_wdata`, in, DATA_W: write-back word for the current beat.
- `mem_wack`, out, 1: write beat consumed this cycle.
- `mem_rvalid`, out, 1: `mem_rdata` is valid this cycle.
- `mem_rdata`, out, DATA_W: refill word.
- `mem_ready`, out, 1: one-cycle completion pulse.
- `mem_perr`, out, 1: parity error on a refill beat.

## Operation
- States are IDLE, WAIT, XFER, DONE and HOLD.
- **IDLE:** if `mem_req`=1, latch `mem_we` and `mem_addr`, clear the beat counter, and load the latency counter with LATENCY. Go to WAIT, or go straight to XFER if LATENCY=0.
- **WAIT:** decrement the latency counter each cycle. Go to XFER in the cycle the counter reaches 1.
- **XFER:** one beat per cycle. Beat k = 0..WORDS-1 addresses word k of the latched line.
  - Refill: `mem_rvalid`=1 and `mem_rdata` = stored word k.
  - Write-back: `mem_wack`=1, and `mem_wdata` is written to word k at the closing clock edge. The requester advances to word k+1 on that same edge.
  - Leave XFER after beat WORDS-1.
- **DONE:** `mem_ready`=1 for exactly one cycle, then go to HOLD.
- **HOLD:** wait for `mem_req`=0, then go to IDLE. This stops a request still held high in the cycle after `mem_ready` from being re-accepted.
- `mem_req` falling during WAIT or XFER is ignored; the transaction completes. Changes to `mem_addr` or `mem_we` after accept are ignored.
- Counter widths: latency counter is clog2(LATENCY+1) bits, minimum 1. Beat counter is clog2(WORDS) bits, minimum 1, and wraps to 0 only on exit.
- Storage is never reset; its contents are undefined until written.

## Timing
- Reset value of every output is 0. Reset asserted mid-transaction returns the block to IDLE immediately. A write-back interrupted by reset leaves earlier beats committed and later beats unwritten.
- Cycle 0 is the IDLE cycle in which `mem_req` is sampled high.
  - WAIT occupies cycles 1..LATENCY.
  - Beats occupy cycles LATENCY+1 .. LATENCY+WORDS.
  - `mem_ready` is high in cycle LATENCY+WORDS+1.
- Earliest next accept is 2 cycles after `mem_ready` (one HOLD cycle with `mem_req` low, then IDLE).
- All outputs are decoded from registered state and counters. No input-to-output combinational path.

## Configuration
- `MEM_RESP_PARITY_EN` defined:
  - Each stored word carries an even-parity bit, computed on write.
  - On each refill beat the parity is recomputed. `mem_perr`=1 in the same cycle as `mem_rvalid` when it mismatches.
  - The data is still returned.
- Undefined: no parity storage, and `mem_perr` is tied to 0.

## Structure
- Shared package `mem_resp_pkg` holds:
  - the state enum (IDLE, WAIT, XFER, DONE, HOLD);
  - the `parity_f` function;
  - the default parameter constants.
- Sub-module `mem_resp_line_store`: the DEPTH×WORDS word array with synchronous write and combinational read by {line, beat}. It includes the parity bit under the macro.

## Test plan
- **Write then read.** Stimulus: write-back to line 5, words 0xA0..0xA3, LATENCY=8, WORDS=4. Required:
  - `mem_wack` in cycles 9–12 and `mem_ready` in cycle 13.
  - A subsequent refill of line 5 returns 0xA0..0xA3 on `mem_rvalid` in cycles 9–12.
- **Zero latency.** Build with LATENCY=0 and refill line 0. Required: beats in cycles 1–4 and `mem_ready` in cycle 5.
- **Request held high.** `mem_req` stays high for 3 cycles after `mem_ready`. Required: no second accept. Dropping `mem_req`, then raising it again, starts a new transaction whose first beat arrives LATENCY+1 cycles after accept.
- **Reset mid-transfer.** Assert `rst_n`=0 during write beat 2. Required:
  - All outputs 0 next cycle and the state is IDLE.
  - A later refill returns new words 0–1 and the old words 2–3.
- **Address change after accept.** Change `mem_addr` from 7 to 9 during WAIT. Required: line 7 is served.
- **Parity** (`MEM_RESP_PARITY_EN`). Force-flip one stored bit of line 3, word 1, then refill line 3. Required: `mem_perr`=1 only on beat 1.
